// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared constants and state type for the output port arbiter
package noc_arb_pkg;

    localparam int ARB_NUM_PORTS = 5;
    localparam int PORT_IDX_W    = $clog2(ARB_NUM_PORTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic [PORT_IDX_W-1:0] PORT_NORTH = 3'd0;
    localparam logic [PORT_IDX_W-1:0] PORT_EAST  = 3'd1;
    localparam logic [PORT_IDX_W-1:0] PORT_SOUTH = 3'd2;
    localparam logic [PORT_IDX_W-1:0] PORT_WEST  = 3'd3;
    localparam logic [PORT_IDX_W-1:0] PORT_LOCAL = 3'd4;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-priority encoder: first set request at or above ptr, wrapping
module rr_priority_pick
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int IDX_W     = PORT_IDX_W
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     pick_o,
    output logic                 any_o
);

    // Scan farthest-from-ptr first so the closest set bit is the last write.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_PORTS]) begin
                pick_o = IDX_W'((int'(ptr_i) + k) % NUM_PORTS);
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - packet-granular round-robin output port arbiter; ARB_TIMEOUT_EN adds forced revoke
module output_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS      = ARB_NUM_PORTS,
    parameter int INPUT_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            release_i,
    input  logic [NUM_PORTS*INPUT_SIZE-1:0] flit_in_i,
    input  logic [NUM_PORTS-1:0]            flit_valid_in_i,
    input  logic                            downstream_stall_i,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic [NUM_PORTS-1:0]            stall_out_o,
    output logic [INPUT_SIZE-1:0]           flit_out_o,
    output logic                            flit_valid_out_o,
    output logic                            timeout_err_o
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]     grant_q, grant_d;
    logic [INPUT_SIZE-1:0]    flit_q, flit_d;
    logic                     fvalid_q, fvalid_d;
    logic                     terr_q, terr_d;
    logic [IDX_W-1:0]         pick;
    logic                     any_req;
    logic [INPUT_SIZE-1:0]    owner_flit;
    logic                     owner_valid;
    logic                     owner_release;
    logic                     timeout_hit;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    always_comb begin
        owner_flit    = '0;
        owner_valid   = 1'b0;
        owner_release = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_flit    = flit_in_i[i*INPUT_SIZE +: INPUT_SIZE];
                owner_valid   = flit_valid_in_i[i];
                owner_release = release_i[i];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter sits at zero through IDLE, so it is already cleared on BUSY entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE)
            cnt_d = '0;
        else if (!downstream_stall_i)
            cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q == ST_BUSY) && !owner_release && !downstream_stall_i
                         && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        terr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    state_d       = ST_BUSY;
                    owner_d       = pick;
                    grant_d[pick] = 1'b1;
                end
            end
            ST_BUSY: begin
                if (owner_release || timeout_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
                    terr_d  = timeout_hit;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fvalid_d = (state_q == ST_BUSY) && owner_valid && !downstream_stall_i;
        flit_d   = fvalid_d ? owner_flit : flit_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            flit_q   <= '0;
            fvalid_q <= 1'b0;
            terr_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            flit_q   <= flit_d;
            fvalid_q <= fvalid_d;
            terr_q   <= terr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Waiting requesters are held off; only the owner sees the link stall.
    always_comb begin
        stall_out_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == ST_BUSY) && (owner_q == IDX_W'(i)))
                stall_out_o[i] = downstream_stall_i;
            else
                stall_out_o[i] = req_i[i];
        end
    end

    assign grant_o          = grant_q;
    assign flit_out_o       = flit_q;
    assign flit_valid_out_o = fvalid_q;
    assign timeout_err_o    = terr_q;

endmodule
